process_sched: RTL and testbench
================================

Name: process_sched

Overview:
- Read-sequencing controller for the convolution process datapath (weight update, multiply-accumulate array, kernel-accumulate stage).
- After a start request and weight-load completion, it walks the loop nest ky → coGroup → woGroup → kx → ciGroup.
- Each cycle it issues one feature/weight buffer read (depth plus valid), and drives compute enable, current ky and line-end toward the accumulate stage.
- Supports downstream hold and signals done.

Parameters:
DEPTHWIDTH, 9, width of buffer depth addresses and group counts
KWIDTH, 4, width of kx/ky counts and counters

Ports:
I_clk  in  1  clock
I_rst  in  1  synchronous active-high reset
I_start  in  1  single-cycle start request for one layer pass
I_load_done  in  1  weight load complete (level)
I_hold  in  1  downstream back-pressure; no read issued while high
I_ciGroup  in  DEPTHWIDTH  input-channel groups per kernel tap
I_woGroup  in  DEPTHWIDTH  output-pixel groups per line
I_coGroup  in  DEPTHWIDTH  output-channel groups
I_kx_num  in  KWIDTH  kernel width
I_ky_num  in  KWIDTH  kernel height
O_rd_dv  out  1  read valid (one beat)
O_rd_fdepth  out  DEPTHWIDTH  feature buffer read depth
O_rd_wdepth  out  DEPTHWIDTH  weight buffer read depth
O_compute_en  out  1  high while in RUN or LINE_END
O_ky  out  KWIDTH  current kernel row
O_line_end  out  1  one-cycle pulse after the last beat of a ky row
O_busy  out  1  high in any state other than IDLE
O_done  out  1  one-cycle pulse at pass completion

Behaviour:
- Reset: state IDLE, all counters 0, every output 0. Reset mid-pass aborts immediately with no done pulse.
- Configuration inputs are sampled into registers on the accepted I_start; later input changes are ignored until the next pass.
- States:
  - IDLE: I_start → WAIT_LOAD. If any sampled count (ci, wo, co, kx, ky) is zero → DONE instead.
  - WAIT_LOAD: I_load_done=1 → RUN on the next edge.
  - RUN: beat = (state==RUN && !I_hold). O_rd_dv = beat, combinational from registered state/counters, zero latency. Counters advance only on beat.
  - LINE_END: one cycle. O_line_end=1. ky advances; if ky was last → DONE, else → RUN.
  - DONE: one cycle. O_done=1 → IDLE.
- I_start in any state other than IDLE is ignored.
- Counter nesting (innermost first): ci (0..ciGroup-1), kx, wo, co. Each wraps to 0 when its inner counter wraps at its max.
- On the beat where ci, kx, wo and co are all at max: counters clear and state → LINE_END.
- Addresses, computed modulo 2^DEPTHWIDTH, zero when O_rd_dv=0:
  - fdepth = (wo + kx)*ciGroup + ci
  - wdepth = ((co*ky_num + ky)*kx_num + kx)*ciGroup + ci
- Beats per ky row = ciGroup*kx*woGroup*coGroup. Total pass cycles with no hold = 1 (WAIT_LOAD exit) + ky*(beats+1) + 1.
- I_hold asserted on the final beat of a row delays the LINE_END transition until that beat issues.
- O_ky holds the current row through its LINE_END cycle and returns to 0 in DONE/IDLE.
- I_load_done dropping during RUN has no effect.

Decomposition:
- Shared package (proc_pkg): state encoding (IDLE, WAIT_LOAD, RUN, LINE_END, DONE) and default widths DEPTHWIDTH/KWIDTH.
- One natural sub-module, sched_loop_cnt: a wrap counter with enable, max and wrap-out. Instantiate five times, chained.
- The address arithmetic stays in the top module.

Test Plan:
- ci=2, kx=3, ky=3, wo=2, co=1, load_done already high, start pulse:
  - 12 rd_dv beats per row, 3 line_end pulses, 36 beats total, done at cycle 41 after start.
  - First fdepths 0,1,2,3,4,5.
- Same config, I_hold high for 4 cycles mid-row: no rd_dv during the hold, address sequence unchanged, done delayed exactly 4 cycles.
- Start with load_done low for 10 cycles: busy=1, no rd_dv, compute_en=0. RUN begins the cycle after load_done rises.
- ciGroup=0, start: done pulses 1 cycle later, no rd_dv or line_end, busy for 1 cycle.
- co=2, ci=1, kx=1, ky=2, wo=1: wdepth sequence 0,2 for ky=0, then 1,3 for ky=1; fdepth 0 on all beats.
- Reset asserted mid-RUN, then a new start: outputs 0 the cycle after reset, no done pulse; the new pass restarts from address 0 with the full beat count.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and default widths for the convolution process read sequencer.
package proc_pkg;

  localparam int unsigned DefDepthWidth = 9;
  localparam int unsigned DefKWidth     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLoad,
    StRun,
    StLineEnd,
    StDone
  } sched_state_e;

endpackage

// File: rtl/sched_loop_cnt.sv
// Wrap counter for one loop level: counts on enable, wraps to zero at max and flags the wrap.
module sched_loop_cnt #(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] cnt_o,
  output logic             wrap_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == max_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/process_sched.sv
// Read sequencer for the convolution process datapath: walks ky/co/wo/kx/ci and issues one
// feature/weight buffer read per unheld RUN cycle.
module process_sched
  import proc_pkg::*;
#(
  parameter int unsigned DEPTHWIDTH = DefDepthWidth,
  parameter int unsigned KWIDTH     = DefKWidth
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_start,
  input  logic                  I_load_done,
  input  logic                  I_hold,
  input  logic [DEPTHWIDTH-1:0] I_ciGroup,
  input  logic [DEPTHWIDTH-1:0] I_woGroup,
  input  logic [DEPTHWIDTH-1:0] I_coGroup,
  input  logic [KWIDTH-1:0]     I_kx_num,
  input  logic [KWIDTH-1:0]     I_ky_num,
  output logic                  O_rd_dv,
  output logic [DEPTHWIDTH-1:0] O_rd_fdepth,
  output logic [DEPTHWIDTH-1:0] O_rd_wdepth,
  output logic                  O_compute_en,
  output logic [KWIDTH-1:0]     O_ky,
  output logic                  O_line_end,
  output logic                  O_busy,
  output logic                  O_done
);

  sched_state_e state_q, state_d;

  logic [DEPTHWIDTH-1:0] ci_group_q, ci_group_d;
  logic [DEPTHWIDTH-1:0] wo_group_q, wo_group_d;
  logic [DEPTHWIDTH-1:0] co_group_q, co_group_d;
  logic [KWIDTH-1:0]     kx_num_q, kx_num_d;
  logic [KWIDTH-1:0]     ky_num_q, ky_num_d;

  logic                  start_acc;
  logic                  cfg_zero;
  logic                  beat;
  logic                  row_step;

  logic [DEPTHWIDTH-1:0] ci_cnt, wo_cnt, co_cnt;
  logic [KWIDTH-1:0]     kx_cnt, ky_cnt;
  logic                  ci_wrap, kx_wrap, wo_wrap, co_wrap, ky_wrap;

  logic [DEPTHWIDTH-1:0] kx_ext, ky_ext, kx_num_ext, ky_num_ext;
  logic [DEPTHWIDTH-1:0] fdepth, wdepth;

  assign start_acc = (state_q == StIdle) && I_start;
  assign cfg_zero  = (I_ciGroup == '0) || (I_woGroup == '0) || (I_coGroup == '0) ||
                     (I_kx_num == '0) || (I_ky_num == '0);
  assign beat      = (state_q == StRun) && !I_hold;
  assign row_step  = (state_q == StLineEnd);

  always_comb begin
    ci_group_d = ci_group_q;
    wo_group_d = wo_group_q;
    co_group_d = co_group_q;
    kx_num_d   = kx_num_q;
    ky_num_d   = ky_num_q;
    if (start_acc) begin
      ci_group_d = I_ciGroup;
      wo_group_d = I_woGroup;
      co_group_d = I_coGroup;
      kx_num_d   = I_kx_num;
      ky_num_d   = I_ky_num;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= StIdle;
      ci_group_q <= '0;
      wo_group_q <= '0;
      co_group_q <= '0;
      kx_num_q   <= '0;
      ky_num_q   <= '0;
    end else begin
      state_q    <= state_d;
      ci_group_q <= ci_group_d;
      wo_group_q <= wo_group_d;
      co_group_q <= co_group_d;
      kx_num_q   <= kx_num_d;
      ky_num_q   <= ky_num_d;
    end
  end

  // Innermost first: ci -> kx -> wo -> co; co wrapping marks the last beat of a ky row.
  sched_loop_cnt #(.Width(DEPTHWIDTH)) u_cnt_ci (
    .clk_i  (I_clk),
    .rst_i  (I_rst),
    .clr_i  (start_acc),
    .en_i   (beat),
    .max_i  (ci_group_q - 1'b1),
    .cnt_o  (ci_cnt),
    .wrap_o (ci_wrap)
  );

  sched_loop_cnt #(.Width(KWIDTH)) u_cnt_kx (
    .clk_i  (I_clk),
    .rst_i  (I_rst),
    .clr_i  (start_acc),
    .en_i   (ci_wrap),
    .max_i  (kx_num_q - 1'b1),
    .cnt_o  (kx_cnt),
    .wrap_o (kx_wrap)
  );

  sched_loop_cnt #(.Width(DEPTHWIDTH)) u_cnt_wo (
    .clk_i  (I_clk),
    .rst_i  (I_rst),
    .clr_i  (start_acc),
    .en_i   (kx_wrap),
    .max_i  (wo_group_q - 1'b1),
    .cnt_o  (wo_cnt),
    .wrap_o (wo_wrap)
  );

  sched_loop_cnt #(.Width(DEPTHWIDTH)) u_cnt_co (
    .clk_i  (I_clk),
    .rst_i  (I_rst),
    .clr_i  (start_acc),
    .en_i   (wo_wrap),
    .max_i  (co_group_q - 1'b1),
    .cnt_o  (co_cnt),
    .wrap_o (co_wrap)
  );

  // ky steps during LINE_END so O_ky still shows the finishing row on that cycle.
  sched_loop_cnt #(.Width(KWIDTH)) u_cnt_ky (
    .clk_i  (I_clk),
    .rst_i  (I_rst),
    .clr_i  (start_acc),
    .en_i   (row_step),
    .max_i  (ky_num_q - 1'b1),
    .cnt_o  (ky_cnt),
    .wrap_o (ky_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (I_start) state_d = cfg_zero ? StDone : StWaitLoad;
      StWaitLoad: if (I_load_done) state_d = StRun;
      StRun:      if (co_wrap) state_d = StLineEnd;
      StLineEnd:  state_d = ky_wrap ? StDone : StRun;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  assign kx_ext     = DEPTHWIDTH'(kx_cnt);
  assign ky_ext     = DEPTHWIDTH'(ky_cnt);
  assign kx_num_ext = DEPTHWIDTH'(kx_num_q);
  assign ky_num_ext = DEPTHWIDTH'(ky_num_q);

  // Both addresses wrap modulo 2^DEPTHWIDTH by truncation.
  assign fdepth = (wo_cnt + kx_ext) * ci_group_q + ci_cnt;
  assign wdepth = ((co_cnt * ky_num_ext + ky_ext) * kx_num_ext + kx_ext) * ci_group_q + ci_cnt;

  always_comb begin
    O_rd_dv      = beat;
    O_rd_fdepth  = beat ? fdepth : '0;
    O_rd_wdepth  = beat ? wdepth : '0;
    O_compute_en = (state_q == StRun) || (state_q == StLineEnd);
    O_ky         = ky_cnt;
    O_line_end   = (state_q == StLineEnd);
    O_busy       = (state_q != StIdle);
    O_done       = (state_q == StDone);
  end

endmodule

// File: tb/tb_process_sched.sv
// Bench for process_sched: event-list model of the loop nest checked every cycle, plus
// hand-computed pass-level expectations.
module tb_process_sched;

  localparam int unsigned DW = 9;
  localparam int unsigned KW = 4;
  localparam int EvBeat = 0;
  localparam int EvLine = 1;
  localparam int EvDone = 2;

  typedef struct {
    int          kind;
    logic [3:0]  ky;
    logic [8:0]  f;
    logic [8:0]  w;
  } ev_t;

  logic          I_clk = 1'b0;
  logic          I_rst = 1'b1;
  logic          I_start = 1'b0;
  logic          I_load_done = 1'b0;
  logic          I_hold = 1'b0;
  logic [DW-1:0] I_ciGroup = '0, I_woGroup = '0, I_coGroup = '0;
  logic [KW-1:0] I_kx_num = '0, I_ky_num = '0;
  logic          O_rd_dv, O_compute_en, O_line_end, O_busy, O_done;
  logic [DW-1:0] O_rd_fdepth, O_rd_wdepth;
  logic [KW-1:0] O_ky;

  process_sched dut (
    .I_clk        (I_clk),
    .I_rst        (I_rst),
    .I_start      (I_start),
    .I_load_done  (I_load_done),
    .I_hold       (I_hold),
    .I_ciGroup    (I_ciGroup),
    .I_woGroup    (I_woGroup),
    .I_coGroup    (I_coGroup),
    .I_kx_num     (I_kx_num),
    .I_ky_num     (I_ky_num),
    .O_rd_dv      (O_rd_dv),
    .O_rd_fdepth  (O_rd_fdepth),
    .O_rd_wdepth  (O_rd_wdepth),
    .O_compute_en (O_compute_en),
    .O_ky         (O_ky),
    .O_line_end   (O_line_end),
    .O_busy       (O_busy),
    .O_done       (O_done)
  );

  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Model state: 0 idle, 1 waiting for weight load, 2 consuming the event list.
  int  mode = 0;
  ev_t q[$];
  int  n_dv, n_le, n_done, done_off, start_cyc;
  int  first_f[8];
  int  first_w[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic build(input int ci, input int wo, input int co, input int kx, input int ky);
    ev_t e;
    int  v;
    q.delete();
    if (ci != 0 && wo != 0 && co != 0 && kx != 0 && ky != 0) begin
      for (int y = 0; y < ky; y++) begin
        for (int o = 0; o < co; o++)
          for (int p = 0; p < wo; p++)
            for (int x = 0; x < kx; x++)
              for (int c = 0; c < ci; c++) begin
                e.kind = EvBeat;
                e.ky   = 4'(y);
                v      = (p + x) * ci + c;
                e.f    = v[8:0];
                v      = ((o * ky + y) * kx + x) * ci + c;
                e.w    = v[8:0];
                q.push_back(e);
              end
        e.kind = EvLine;
        e.ky   = 4'(y);
        e.f    = '0;
        e.w    = '0;
        q.push_back(e);
      end
    end
    e.kind = EvDone;
    e.ky   = '0;
    e.f    = '0;
    e.w    = '0;
    q.push_back(e);
  endtask

  task automatic model_loop();
    logic          e_dv, e_ce, e_le, e_busy, e_done;
    logic [KW-1:0] e_ky;
    logic [DW-1:0] e_f, e_w;
    logic [26:0]   exp_v, act_v;
    forever begin
      @(negedge I_clk);
      if (I_rst) begin
        mode = 0;
        q.delete();
      end else begin
        if (mode == 2 && q.size() == 0) mode = 0;
        e_dv = 1'b0; e_ce = 1'b0; e_le = 1'b0; e_done = 1'b0;
        e_busy = (mode != 0);
        e_ky = '0; e_f = '0; e_w = '0;
        if (mode == 2) begin
          case (q[0].kind)
            EvBeat: begin
              e_ce = 1'b1;
              e_ky = q[0].ky;
              if (!I_hold) begin
                e_dv = 1'b1;
                e_f  = q[0].f;
                e_w  = q[0].w;
              end
            end
            EvLine: begin
              e_ce = 1'b1;
              e_le = 1'b1;
              e_ky = q[0].ky;
            end
            default: e_done = 1'b1;
          endcase
        end
        exp_v = {e_dv, e_ce, e_le, e_busy, e_done, e_ky, e_f, e_w};
        act_v = {O_rd_dv, O_compute_en, O_line_end, O_busy, O_done, O_ky, O_rd_fdepth,
                 O_rd_wdepth};
        checks++;
        if (act_v !== exp_v) begin
          failures++;
          $display("FAIL cycle_%0d {dv,ce,le,busy,done,ky,f,w} got=%h expected=%h",
                   cyc, act_v, exp_v);
        end
        if (O_rd_dv === 1'b1) begin
          if (n_dv < 8) begin
            first_f[n_dv] = int'(O_rd_fdepth);
            first_w[n_dv] = int'(O_rd_wdepth);
          end
          n_dv++;
        end
        if (O_line_end === 1'b1) n_le++;
        if (O_done === 1'b1) begin
          n_done++;
          done_off = cyc - start_cyc;
        end
        case (mode)
          0: if (I_start) begin
            build(int'(I_ciGroup), int'(I_woGroup), int'(I_coGroup), int'(I_kx_num),
                  int'(I_ky_num));
            n_dv = 0; n_le = 0; n_done = 0; done_off = -1;
            start_cyc = cyc;
            mode = (q.size() == 1) ? 2 : 1;
          end
          1: if (I_load_done) mode = 2;
          default: begin
            if (q[0].kind != EvBeat || !I_hold) void'(q.pop_front());
            if (q.size() == 0) mode = 0;
          end
        endcase
      end
    end
  endtask

  task automatic cfg(input int ci, input int wo, input int co, input int kx, input int ky);
    I_ciGroup = DW'(ci);
    I_woGroup = DW'(wo);
    I_coGroup = DW'(co);
    I_kx_num  = KW'(kx);
    I_ky_num  = KW'(ky);
  endtask

  task automatic pulse_start();
    @(posedge I_clk); #1;
    I_start = 1'b1;
    @(posedge I_clk); #1;
    I_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (n_done == 0 && i < budget) begin
      @(posedge I_clk);
      i++;
    end
    #1;
    checks++;
    if (n_done == 0) begin
      failures++;
      $display("FAIL %s_timeout got=no_done expected=done_within_%0d", name, budget);
    end
    repeat (2) @(posedge I_clk);
    #1;
  endtask

  initial begin
    fork
      model_loop();
    join_none
    repeat (3) @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    check("reset_busy", int'(O_busy), 0);
    check("reset_dv", int'(O_rd_dv), 0);

    // Baseline pass; a stray start mid-pass must be ignored.
    cfg(2, 2, 1, 3, 3);
    I_load_done = 1'b1;
    pulse_start();
    cfg(5, 5, 5, 5, 5);
    repeat (18) @(posedge I_clk);
    #1;
    I_start = 1'b1;
    @(posedge I_clk); #1;
    I_start = 1'b0;
    wait_done("base", 200);
    check("base_beats", n_dv, 36);
    check("base_line_ends", n_le, 3);
    check("base_done_cycle", done_off, 41);
    for (int i = 0; i < 6; i++) check($sformatf("base_fdepth%0d", i), first_f[i], i);

    // Four-cycle hold in the middle of the first row.
    cfg(2, 2, 1, 3, 3);
    pulse_start();
    repeat (6) @(posedge I_clk);
    #1;
    I_hold = 1'b1;
    repeat (4) @(posedge I_clk);
    #1;
    I_hold = 1'b0;
    wait_done("hold", 200);
    check("hold_beats", n_dv, 36);
    check("hold_done_cycle", done_off, 45);
    check("hold_fdepth5", first_f[5], 5);

    // Weight load arrives late.
    I_load_done = 1'b0;
    pulse_start();
    repeat (5) @(posedge I_clk);
    #1;
    check("wait_busy", int'(O_busy), 1);
    check("wait_compute_en", int'(O_compute_en), 0);
    check("wait_no_beats", n_dv, 0);
    repeat (5) @(posedge I_clk);
    #1;
    I_load_done = 1'b1;
    wait_done("late_load", 200);
    check("late_load_done_cycle", done_off, 51);
    check("late_load_beats", n_dv, 36);

    // Zero ciGroup goes straight to DONE.
    cfg(0, 2, 1, 3, 3);
    pulse_start();
    wait_done("zero", 20);
    check("zero_done_cycle", done_off, 1);
    check("zero_beats", n_dv, 0);
    check("zero_line_ends", n_le, 0);

    // Weight addressing across co and ky.
    cfg(1, 1, 2, 1, 2);
    pulse_start();
    wait_done("wdepth", 50);
    check("wd_beats", n_dv, 4);
    check("wd0", first_w[0], 0);
    check("wd1", first_w[1], 2);
    check("wd2", first_w[2], 1);
    check("wd3", first_w[3], 3);
    check("wd_fdepth_sum", first_f[0] + first_f[1] + first_f[2] + first_f[3], 0);
    check("wd_done_cycle", done_off, 8);

    // Reset mid-RUN aborts; a fresh pass then runs in full.
    cfg(2, 2, 1, 3, 3);
    pulse_start();
    repeat (9) @(posedge I_clk);
    #1;
    I_rst = 1'b1;
    @(posedge I_clk); #1;
    I_rst = 1'b0;
    check("abort_busy", int'(O_busy), 0);
    check("abort_dv", int'(O_rd_dv), 0);
    check("abort_ky", int'(O_ky), 0);
    repeat (3) @(posedge I_clk);
    #1;
    check("abort_no_done", n_done, 0);
    pulse_start();
    wait_done("restart", 200);
    check("restart_beats", n_dv, 36);
    check("restart_fdepth0", first_f[0], 0);
    check("restart_done_cycle", done_off, 41);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
